music_box_recording_playback: RTL and testbench

Playback stage directly downstream of the recording stage: it reads back the 8-bit samples stored one per 16-bit SDRAM word, starting at address 0, and presents them to the audio output path at the 22050 Hz sample rate. It runs entirely in the 50 MHz domain. It uses a small prefetch FIFO so SDRAM latency never stalls the sample stream. It is active only while the state controller selects its state, and it asserts `stateComplete` when the recording has been fully played.

---
 rtl/music_box_recording_playback.sv | 157 +++++++++++++++
 tb/tb_music_box_recording_playback.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_box_recording_playback.sv
// Playback stage: prefetches recorded 8-bit samples from SDRAM and streams them out on each sample tick.
// Optional MUSICBOX_PLAYBACK_LOOP_EN: wrap to address 0 and play forever instead of finishing after one pass.
module music_box_recording_playback #(
  parameter logic [4:0]  PLAY_STATE   = 5'd5,
  parameter int unsigned SAMPLE_COUNT = 110250,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic [4:0]  mainState,
  input  logic        sample_tick,
  output logic        stateComplete,
  output logic [7:0]  audio_sample,
  output logic        audio_valid,
  output logic [31:0] debugString,
  output logic [24:0] sdram_inputAddress,
  output logic [15:0] sdram_writeData,
  input  logic [15:0] sdram_readData,
  output logic        sdram_isWriting,
  output logic        sdram_inputValid,
  input  logic        sdram_outputValid,
  input  logic        sdram_recievedCommand,
  input  logic        sdram_isBusy
);

`ifdef MUSICBOX_PLAYBACK_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = 17;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(SAMPLE_COUNT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SAMPLE_COUNT - 1);
  localparam logic [PTR_W:0]   FULL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [7:0]       MIDSCALE = 8'd128;

  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_PLAY, S_DONE} state_t;

  state_t           r_state;
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_read_addr;
  logic [CNT_W-1:0] r_played;
  logic [15:0]      r_underrun;
  logic             r_req;
  logic             r_inflight;
  logic             r_valid;
  logic             r_complete;
  logic [7:0]       r_sample;
  logic [24:0]      r_addr_out;

  logic             w_exit;
  logic             w_active;
  logic             w_more;
  logic             w_push;
  logic             w_tick;
  logic             w_pop;
  logic             w_can_req;
  logic             w_reads_done;
  logic [CNT_W-1:0] w_addr_next;
  logic [CNT_W-1:0] w_played_next;
  logic             w_unused;

  assign w_exit        = reset || (mainState != PLAY_STATE);
  assign w_active      = (r_state == S_PREFETCH) || (r_state == S_PLAY);
  assign w_more        = LOOP_EN || (r_read_addr < TOTAL);
  assign w_push        = w_active && r_inflight && sdram_outputValid;
  assign w_tick        = (r_state == S_PLAY) && sample_tick && (LOOP_EN || (r_played != TOTAL));
  assign w_pop         = w_tick && (r_count != '0);
  // One read in flight at a time, so a free slot only needs checking while idle.
  assign w_can_req     = w_active && !r_req && !r_inflight && (r_count < FULL) && w_more && !sdram_isBusy;
  assign w_reads_done  = !LOOP_EN && (r_read_addr == TOTAL) && !r_req && !r_inflight;
  assign w_addr_next   = (LOOP_EN && (r_read_addr == LAST)) ? '0 : r_read_addr + CNT_W'(1);
  assign w_played_next = (LOOP_EN && (r_played == LAST)) ? '0 : r_played + CNT_W'(1);
  assign w_unused      = ^sdram_readData[15:8];

  always_ff @(posedge clock_50Mhz) begin
    if (w_push && !w_exit) r_fifo[r_wr_ptr] <= sdram_readData[7:0];
  end

  always_ff @(posedge clock_50Mhz) begin
    if (w_exit) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_read_addr <= '0;
      r_played    <= '0;
      r_underrun  <= '0;
      r_req       <= 1'b0;
      r_inflight  <= 1'b0;
      r_valid     <= 1'b0;
      r_complete  <= 1'b0;
      r_sample    <= MIDSCALE;
      r_addr_out  <= '0;
    end else begin
      r_valid <= 1'b0;

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);

      // Request stays asserted with a stable address until the controller accepts it.
      if (w_can_req) begin
        r_req      <= 1'b1;
        r_addr_out <= 25'(r_read_addr);
      end else if (r_req && sdram_recievedCommand) begin
        r_req       <= 1'b0;
        r_inflight  <= 1'b1;
        r_read_addr <= w_addr_next;
      end
      if (w_push) r_inflight <= 1'b0;

      // Starved ticks still pulse valid but repeat the previous sample.
      if (w_tick) begin
        r_valid <= 1'b1;
        if (w_pop) begin
          r_sample <= r_fifo[r_rd_ptr];
          r_played <= w_played_next;
        end else if (r_underrun != 16'hFFFF) begin
          r_underrun <= r_underrun + 16'd1;
        end
      end

      case (r_state)
        S_IDLE:     r_state <= S_PREFETCH;
        S_PREFETCH: if ((r_count == FULL) || w_reads_done) r_state <= S_PLAY;
        S_PLAY: begin
          if (!LOOP_EN && (r_played == TOTAL)) begin
            r_state    <= S_DONE;
            r_complete <= 1'b1;
            r_sample   <= MIDSCALE;
          end
        end
        S_DONE: begin
          r_complete <= 1'b1;
          r_sample   <= MIDSCALE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stateComplete      = r_complete;
  assign audio_sample       = r_sample;
  assign audio_valid        = r_valid;
  assign debugString        = {r_underrun, r_played[15:0]};
  assign sdram_inputAddress = r_addr_out;
  assign sdram_inputValid   = r_req;
  assign sdram_writeData    = 16'd0;
  assign sdram_isWriting    = 1'b0;

endmodule

// File: tb/tb_music_box_recording_playback.sv
// Directed bench for the playback stage with a small SDRAM read model (fixed accept delay and data latency).
`timescale 1ns/1ps
module tb_music_box_recording_playback;

  localparam logic [4:0] PLAY = 5'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  mainState;
  logic        sample_tick;
  logic        stateComplete;
  logic [7:0]  audio_sample;
  logic        audio_valid;
  logic [31:0] debugString;
  logic [24:0] sdram_inputAddress;
  logic [15:0] sdram_writeData;
  logic [15:0] sdram_readData;
  logic        sdram_isWriting;
  logic        sdram_inputValid;
  logic        sdram_outputValid;
  logic        sdram_recievedCommand;
  logic        sdram_isBusy;

  int errors = 0;
  int checks = 0;

  int          m_lat;
  int          m_acc;
  int          m_acc_cnt;
  int          m_lat_cnt;
  int          m_n_acc;
  int          m_n_out;
  bit          m_pending;
  logic [24:0] m_addr;

  always #5 clk = ~clk;

  music_box_recording_playback #(
    .PLAY_STATE(PLAY),
    .SAMPLE_COUNT(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clock_50Mhz(clk),
    .reset(reset),
    .mainState(mainState),
    .sample_tick(sample_tick),
    .stateComplete(stateComplete),
    .audio_sample(audio_sample),
    .audio_valid(audio_valid),
    .debugString(debugString),
    .sdram_inputAddress(sdram_inputAddress),
    .sdram_writeData(sdram_writeData),
    .sdram_readData(sdram_readData),
    .sdram_isWriting(sdram_isWriting),
    .sdram_inputValid(sdram_inputValid),
    .sdram_outputValid(sdram_outputValid),
    .sdram_recievedCommand(sdram_recievedCommand),
    .sdram_isBusy(sdram_isBusy)
  );

  // SDRAM model: accepts after m_acc waiting cycles, returns {8'hA5, addr[7:0]} m_lat cycles later.
  always @(negedge clk) begin
    sdram_recievedCommand = 1'b0;
    sdram_outputValid     = 1'b0;
    if (m_pending) begin
      if (m_lat_cnt == 0) begin
        sdram_outputValid = 1'b1;
        sdram_readData    = {8'hA5, m_addr[7:0]};
        m_pending         = 1'b0;
        m_n_out++;
      end else begin
        m_lat_cnt--;
      end
    end
    if (sdram_inputValid && !m_pending) begin
      if (m_acc_cnt >= m_acc) begin
        sdram_recievedCommand = 1'b1;
        m_addr    = sdram_inputAddress;
        m_pending = 1'b1;
        m_lat_cnt = m_lat - 1;
        m_acc_cnt = 0;
        m_n_acc++;
      end else begin
        m_acc_cnt++;
      end
    end
  end

  task automatic model_cfg(input int lat, input int acc);
    m_lat     = lat;
    m_acc     = acc;
    m_acc_cnt = 0;
    m_lat_cnt = 0;
    m_pending = 1'b0;
    m_n_acc   = 0;
    m_n_out   = 0;
  endtask

  task automatic leave_state();
    mainState = 5'd0;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_tick(input int gap, output logic v, output logic [7:0] s);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    v = audio_valid;
    s = audio_sample;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    mainState = PLAY;
    repeat (3) @(negedge clk);
    checks++; if (stateComplete !== 1'b0) begin errors++; $display("FAIL reset_complete: got %b want 0", stateComplete); end
    checks++; if (audio_sample !== 8'd128) begin errors++; $display("FAIL reset_sample: got %0d want 128", audio_sample); end
    checks++; if (audio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", audio_valid); end
    checks++; if (sdram_inputValid !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", sdram_inputValid); end
    checks++; if (sdram_inputAddress !== 25'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", sdram_inputAddress); end
    checks++; if (debugString !== 32'd0) begin errors++; $display("FAIL reset_debug: got %h want 0", debugString); end
    checks++; if (sdram_isWriting !== 1'b0) begin errors++; $display("FAIL reset_iswriting: got %b want 0", sdram_isWriting); end
    checks++; if (sdram_writeData !== 16'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", sdram_writeData); end
    reset     = 1'b0;
    mainState = 5'd0;
    repeat (2) @(negedge clk);
  endtask

`ifndef MUSICBOX_PLAYBACK_LOOP_EN
  task automatic test_playback();
    logic       v;
    logic [7:0] s;
    model_cfg(3, 0);
    mainState = PLAY;
    @(negedge clk);
    checks++; if (sdram_inputValid !== 1'b0) begin errors++; $display("FAIL play_req_early: got %b want 0", sdram_inputValid); end
    @(negedge clk);
    checks++; if (sdram_inputValid !== 1'b1 || sdram_inputAddress !== 25'd0) begin
      errors++; $display("FAIL play_first_req: got valid=%b addr=%0d want valid=1 addr=0", sdram_inputValid, sdram_inputAddress);
    end
    repeat (60) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      do_tick((i == 15) ? 1 : 20, v, s);
      checks++; if (v !== 1'b1 || s !== 8'(i)) begin
        errors++; $display("FAIL play_sample%0d: got valid=%b sample=%0d want valid=1 sample=%0d", i, v, s, i);
      end
    end
    checks++; if (stateComplete !== 1'b0) begin errors++; $display("FAIL play_complete_early: got %b want 0", stateComplete); end
    @(negedge clk);
    checks++; if (stateComplete !== 1'b1) begin errors++; $display("FAIL play_complete: got %b want 1", stateComplete); end
    checks++; if (audio_sample !== 8'd128) begin errors++; $display("FAIL play_done_sample: got %0d want 128", audio_sample); end
    checks++; if (debugString !== {16'd0, 16'd16}) begin errors++; $display("FAIL play_debug: got %h want %h", debugString, {16'd0, 16'd16}); end
    for (int i = 0; i < 3; i++) begin
      do_tick(10, v, s);
      checks++; if (v !== 1'b0 || stateComplete !== 1'b1 || sdram_inputValid !== 1'b0) begin
        errors++; $display("FAIL done_hold%0d: got valid=%b complete=%b req=%b want 0,1,0", i, v, stateComplete, sdram_inputValid);
      end
    end
    leave_state();
    checks++; if (stateComplete !== 1'b0 || debugString !== 32'd0) begin
      errors++; $display("FAIL exit_after_done: got complete=%b debug=%h want 0,0", stateComplete, debugString);
    end
  endtask
`else
  task automatic test_loop();
    logic       v;
    logic [7:0] s;
    model_cfg(3, 0);
    mainState = PLAY;
    repeat (62) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      do_tick(20, v, s);
      checks++; if (v !== 1'b1 || s !== 8'(i % 16) || stateComplete !== 1'b0) begin
        errors++; $display("FAIL loop_sample%0d: got valid=%b sample=%0d complete=%b want 1,%0d,0", i, v, s, stateComplete, i % 16);
      end
    end
    checks++; if (debugString !== {16'd0, 16'd4}) begin errors++; $display("FAIL loop_debug: got %h want %h", debugString, {16'd0, 16'd4}); end
    leave_state();
  endtask
`endif

  task automatic test_busy();
    int seen;
    seen = 0;
    model_cfg(3, 0);
    sdram_isBusy = 1'b1;
    mainState    = PLAY;
    repeat (100) begin
      @(negedge clk);
      if (sdram_inputValid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL busy_block: got %0d request cycles want 0", seen); end
    sdram_isBusy = 1'b0;
    @(negedge clk);
    checks++; if (sdram_inputValid !== 1'b1 || sdram_inputAddress !== 25'd0) begin
      errors++; $display("FAIL busy_release: got valid=%b addr=%0d want 1,0", sdram_inputValid, sdram_inputAddress);
    end
    leave_state();
  endtask

  task automatic test_accept_delay();
    bit stable;
    bit found;
    stable = 1'b1;
    model_cfg(3, 5);
    mainState = PLAY;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (sdram_inputValid !== 1'b1 || sdram_inputAddress !== 25'd0 || m_n_acc != 0) stable = 1'b0;
      @(negedge clk);
    end
    checks++; if (!stable) begin errors++; $display("FAIL accept_hold: got unstable request want valid=1 addr=0 for 5 cycles"); end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (!sdram_inputValid) found = 1'b1;
    end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (sdram_inputValid) found = 1'b1;
    end
    checks++; if (!found || sdram_inputAddress !== 25'd1) begin
      errors++; $display("FAIL accept_next_addr: got found=%b addr=%0d want 1,1", found, sdram_inputAddress);
    end
    checks++; if (m_n_acc != 1 || m_n_out != 1) begin
      errors++; $display("FAIL accept_once: got accepts=%0d returns=%0d want 1,1", m_n_acc, m_n_out);
    end
    leave_state();
  endtask

  task automatic test_underrun();
    logic       v;
    logic [7:0] s;
    logic [7:0] exp_s [8];
    exp_s = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4};
    model_cfg(200, 0);
    mainState = PLAY;
    repeat (1000) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      do_tick(30, v, s);
      checks++; if (v !== 1'b1 || s !== exp_s[i]) begin
        errors++; $display("FAIL underrun_sample%0d: got valid=%b sample=%0d want 1,%0d", i, v, s, exp_s[i]);
      end
    end
    checks++; if (debugString !== {16'd3, 16'd5}) begin errors++; $display("FAIL underrun_debug: got %h want %h", debugString, {16'd3, 16'd5}); end
    leave_state();
  endtask

  task automatic test_exit_midplay();
    logic       v;
    logic [7:0] s;
    bit         found;
    int         base;
    bit         pulsed;
    model_cfg(50, 0);
    mainState = PLAY;
    repeat (300) @(negedge clk);
    do_tick(1, v, s);
    checks++; if (v !== 1'b1 || s !== 8'd0) begin errors++; $display("FAIL exit_first_pop: got valid=%b sample=%0d want 1,0", v, s); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_pending) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL exit_no_accept: got no accepted read want one within 20 cycles"); end
    @(negedge clk);
    mainState = 5'd0;
    base   = m_n_out;
    found  = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (audio_valid) pulsed = 1'b1;
      if (m_n_out > base) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL exit_late_data: got no late return want one within 80 cycles"); end
    repeat (3) @(negedge clk);
    checks++; if (audio_sample !== 8'd128 || pulsed || sdram_inputValid !== 1'b0 || debugString !== 32'd0) begin
      errors++; $display("FAIL exit_idle: got sample=%0d pulsed=%b req=%b debug=%h want 128,0,0,0", audio_sample, pulsed, sdram_inputValid, debugString);
    end
    mainState = PLAY;
    repeat (2) @(negedge clk);
    checks++; if (sdram_inputValid !== 1'b1 || sdram_inputAddress !== 25'd0) begin
      errors++; $display("FAIL reenter_req: got valid=%b addr=%0d want 1,0", sdram_inputValid, sdram_inputAddress);
    end
    repeat (300) @(negedge clk);
    do_tick(2, v, s);
    checks++; if (v !== 1'b1 || s !== 8'd0) begin errors++; $display("FAIL reenter_sample: got valid=%b sample=%0d want 1,0", v, s); end
    leave_state();
  endtask

  initial begin
    reset                 = 1'b1;
    mainState             = 5'd0;
    sample_tick           = 1'b0;
    sdram_isBusy          = 1'b0;
    sdram_readData        = 16'd0;
    sdram_outputValid     = 1'b0;
    sdram_recievedCommand = 1'b0;
    model_cfg(3, 0);
    test_reset();
`ifndef MUSICBOX_PLAYBACK_LOOP_EN
    test_playback();
`else
    test_loop();
`endif
    test_busy();
    test_accept_delay();
    test_underrun();
    test_exit_midplay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
